// File: rtl/fifo_cmd_dev.sv
// fifo_cmd_dev -- command-driven 8-entry x 8-bit FIFO peripheral.
//
// A 12-bit command word on `inst` ({opcode, immediate}) is consumed on every
// rising edge where `inst_wen` is high and the controller is in Ready. The
// head entry and a status byte are presented back to the sequencer so
// programs can test and branch on them.
//
// Ports:
//   clock    in   1  single clock, all state changes on the rising edge
//   reset    in   1  synchronous, active-high
//   inst     in  12  command: inst[11:8] opcode, inst[7:0] immediate
//   inst_wen in   1  command strobe, one command per cycle while high
//   head     out  8  oldest entry, 0 when empty or not Ready
//   status   out  8  {full, empty, ovf, udf, count[3:0]}, 0 when not Ready
//   ready    out  1  high only in state Ready
//   error    out  1  high only in state Error
//
// Opcodes: 0 NOP, 1 PUSH, 2 POP, 3 CLR, 4 XCH (pop+push), 5..F invalid -> Error.
// All outputs decode from registered state only.

module fifo_cmd_dev (
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] inst,
  input  logic        inst_wen,
  output logic [7:0]  head,
  output logic [7:0]  status,
  output logic        ready,
  output logic        error
);

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_READY = 2'd1,
    ST_ERROR = 2'd2
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_PUSH = 4'h1;
  localparam logic [3:0] OP_POP  = 4'h2;
  localparam logic [3:0] OP_CLR  = 4'h3;
  localparam logic [3:0] OP_XCH  = 4'h4;

  state_t      state_reg, state_next;
  logic [7:0]  mem_reg [0:7];
  logic [2:0]  rptr_reg, rptr_next;
  logic [2:0]  wptr_reg, wptr_next;
  logic [3:0]  count_reg, count_next;
  logic        ovf_reg, ovf_next;
  logic        udf_reg, udf_next;

  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_wsel;

  logic [3:0]  opcode;
  logic [7:0]  imm;
  logic        full;
  logic        empty;

  assign opcode = inst[11:8];
  assign imm    = inst[7:0];
  assign full   = (count_reg == 4'd8);
  assign empty  = (count_reg == 4'd0);

  // Next-state and datapath control.
  always_comb begin
    state_next = state_reg;
    rptr_next  = rptr_reg;
    wptr_next  = wptr_reg;
    count_next = count_reg;
    ovf_next   = ovf_reg;
    udf_next   = udf_reg;
    mem_we     = 1'b0;
    mem_wdata  = imm;

    if (reset) begin
      // Reset wins over any command presented in the same cycle.
      state_next = ST_RESET;
      rptr_next  = 3'd0;
      wptr_next  = 3'd0;
      count_next = 4'd0;
      ovf_next   = 1'b0;
      udf_next   = 1'b0;
    end else begin
      case (state_reg)
        ST_RESET: begin
          // Any command seen on this edge is deliberately dropped.
          state_next = ST_READY;
        end

        ST_READY: begin
          if (inst_wen) begin
            case (opcode)
              OP_NOP: begin
              end

              OP_PUSH: begin
                if (full) begin
                  ovf_next = 1'b1;
                end else begin
                  mem_we     = 1'b1;
                  wptr_next  = wptr_reg + 3'd1;
                  count_next = count_reg + 4'd1;
                end
              end

              OP_POP: begin
                if (empty) begin
                  udf_next = 1'b1;
                end else begin
                  rptr_next  = rptr_reg + 3'd1;
                  count_next = count_reg - 4'd1;
                end
              end

              OP_CLR: begin
                rptr_next  = 3'd0;
                wptr_next  = 3'd0;
                count_next = 4'd0;
                ovf_next   = 1'b0;
                udf_next   = 1'b0;
              end

              OP_XCH: begin
                mem_we    = 1'b1;
                wptr_next = wptr_reg + 3'd1;
                if (empty) begin
                  // Nothing to pop: behaves as PUSH and flags the underflow.
                  udf_next   = 1'b1;
                  count_next = count_reg + 4'd1;
                end else begin
                  // When full, wptr == rptr, so the write lands on the slot
                  // being popped this same cycle; nothing live is lost.
                  rptr_next = rptr_reg + 3'd1;
                end
              end

              default: begin
                // Invalid opcode: freeze contents and lock up until reset.
                state_next = ST_ERROR;
              end
            endcase
          end
        end

        ST_ERROR: begin
          state_next = ST_ERROR;
        end

        default: begin
          state_next = ST_ERROR;
        end
      endcase
    end
  end

  // Per-entry write select decoded from the write pointer.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_wsel
      assign mem_wsel[gi] = mem_we && (wptr_reg == 3'(gi));
    end
  endgenerate

  // Storage array; contents are never reset (don't-care after CLR/reset).
  always_ff @(posedge clock) begin
    for (int i = 0; i < 8; i++) begin
      if (mem_wsel[i]) begin
        mem_reg[i] <= mem_wdata;
      end
    end
  end

  // Control state and pointers.
  always_ff @(posedge clock) begin
    state_reg <= state_next;
    rptr_reg  <= rptr_next;
    wptr_reg  <= wptr_next;
    count_reg <= count_next;
    ovf_reg   <= ovf_next;
    udf_reg   <= udf_next;
  end

  // Outputs, decoded only from registered state.
  always_comb begin
    head   = 8'h00;
    status = 8'h00;
    ready  = 1'b0;
    error  = 1'b0;
    case (state_reg)
      ST_READY: begin
        ready  = 1'b1;
        head   = empty ? 8'h00 : mem_reg[rptr_reg];
        status = {full, empty, ovf_reg, udf_reg, count_reg};
      end
      ST_ERROR: begin
        error = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_fifo_cmd_dev.sv
// Directed testbench for fifo_cmd_dev. Each task drives one scenario and
// checks head/status/ready/error against hand-computed values.

module tb_fifo_cmd_dev;

  logic        clock;
  logic        reset;
  logic [11:0] inst;
  logic        inst_wen;
  logic [7:0]  head;
  logic [7:0]  status;
  logic        ready;
  logic        error;

  int total;
  int bad;

  fifo_cmd_dev dut (
    .clock    (clock),
    .reset    (reset),
    .inst     (inst),
    .inst_wen (inst_wen),
    .head     (head),
    .status   (status),
    .ready    (ready),
    .error    (error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Apply one command for one clock edge and sample just after the edge.
  task automatic cmd(input logic wen, input logic [3:0] op, input logic [7:0] imm);
    inst_wen = wen;
    inst     = {op, imm};
    @(posedge clock);
    #1;
    inst_wen = 1'b0;
    $display("txn rst=%0b wen=%0b op=%h imm=%h -> head=%h status=%h ready=%0b error=%0b",
             reset, wen, op, imm, head, status, ready, error);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cmd(1'b1, 4'h1, 8'hAA);
    cmd(1'b1, 4'h1, 8'hAA);
    total++; if (status !== 8'h00) begin bad++; $display("FAIL rst_status got=%h exp=%h", status, 8'h00); end
    total++; if (head !== 8'h00) begin bad++; $display("FAIL rst_head got=%h exp=%h", head, 8'h00); end
    total++; if ({ready, error} !== 2'b00) begin bad++; $display("FAIL rst_ready_error got=%b exp=%b", {ready, error}, 2'b00); end
    reset = 1'b0;
    // First edge with reset low: PUSH AA must be ignored.
    cmd(1'b1, 4'h1, 8'hAA);
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL rst_exit_ready got=%b exp=1", ready); end
    total++; if (status !== 8'h40) begin bad++; $display("FAIL rst_exit_status got=%h exp=%h", status, 8'h40); end
    total++; if (head !== 8'h00) begin bad++; $display("FAIL rst_exit_head got=%h exp=%h", head, 8'h00); end
  endtask

  task automatic test_push_pop();
    cmd(1'b1, 4'h1, 8'h11);
    total++; if (status !== 8'h01 || head !== 8'h11) begin bad++; $display("FAIL push1 got=%h/%h exp=01/11", status, head); end
    cmd(1'b1, 4'h1, 8'h22);
    cmd(1'b1, 4'h1, 8'h33);
    total++; if (head !== 8'h11) begin bad++; $display("FAIL push3_head got=%h exp=11", head); end
    total++; if (status !== 8'h03) begin bad++; $display("FAIL push3_status got=%h exp=03", status); end
    cmd(1'b1, 4'h2, 8'h00);
    total++; if (head !== 8'h22) begin bad++; $display("FAIL pop_head got=%h exp=22", head); end
    total++; if (status !== 8'h02) begin bad++; $display("FAIL pop_status got=%h exp=02", status); end
    cmd(1'b1, 4'h3, 8'h00);
    total++; if (status !== 8'h40 || head !== 8'h00) begin bad++; $display("FAIL clr1 got=%h/%h exp=40/00", status, head); end
  endtask

  task automatic test_hold_nop();
    cmd(1'b1, 4'h1, 8'h42);
    cmd(1'b1, 4'h0, 8'hFF);
    total++; if (status !== 8'h01 || head !== 8'h42) begin bad++; $display("FAIL nop got=%h/%h exp=01/42", status, head); end
    cmd(1'b0, 4'h2, 8'h00);
    total++; if (status !== 8'h01 || head !== 8'h42) begin bad++; $display("FAIL wen_low got=%h/%h exp=01/42", status, head); end
    cmd(1'b1, 4'h3, 8'h00);
  endtask

  task automatic test_overflow();
    logic [7:0] exp_head;
    for (int i = 1; i <= 9; i++) begin
      cmd(1'b1, 4'h1, 8'(i));
      if (i == 8) begin
        total++; if (status !== 8'h88) begin bad++; $display("FAIL fill8_status got=%h exp=88", status); end
      end
    end
    total++; if (status !== 8'hA8) begin bad++; $display("FAIL ovf_status got=%h exp=A8", status); end
    total++; if (head !== 8'h01) begin bad++; $display("FAIL ovf_head got=%h exp=01", head); end
    cmd(1'b1, 4'h1, 8'h0A);
    total++; if (status !== 8'hA8) begin bad++; $display("FAIL ovf_again got=%h exp=A8", status); end
    for (int i = 0; i < 8; i++) begin
      cmd(1'b1, 4'h2, 8'h00);
      exp_head = (i < 7) ? 8'(i + 2) : 8'h00;
      total++; if (head !== exp_head) begin bad++; $display("FAIL ovf_pop%0d_head got=%h exp=%h", i, head, exp_head); end
    end
    total++; if (status !== 8'h60) begin bad++; $display("FAIL ovf_drain_status got=%h exp=60", status); end
    cmd(1'b1, 4'h3, 8'h00);
    total++; if (status !== 8'h40) begin bad++; $display("FAIL clr_ovf got=%h exp=40", status); end
  endtask

  task automatic test_underflow_xch();
    cmd(1'b1, 4'h2, 8'h00);
    total++; if (status !== 8'h50 || head !== 8'h00) begin bad++; $display("FAIL udf got=%h/%h exp=50/00", status, head); end
    cmd(1'b1, 4'h4, 8'h5C);
    // count 1 with sticky udf: {0,0,0,1,0001}
    total++; if (status !== 8'h11) begin bad++; $display("FAIL xch_empty_status got=%h exp=11", status); end
    total++; if (head !== 8'h5C) begin bad++; $display("FAIL xch_empty_head got=%h exp=5C", head); end
    cmd(1'b1, 4'h3, 8'h00);
    total++; if (status !== 8'h40) begin bad++; $display("FAIL clr_udf got=%h exp=40", status); end
  endtask

  task automatic test_xch_full();
    logic [7:0] exp_head;
    for (int i = 0; i < 8; i++) cmd(1'b1, 4'h1, 8'(8'h81 + i));
    cmd(1'b1, 4'h4, 8'hEE);
    total++; if (status !== 8'h88) begin bad++; $display("FAIL xch_full_status got=%h exp=88", status); end
    total++; if (head !== 8'h82) begin bad++; $display("FAIL xch_full_head got=%h exp=82", head); end
    for (int i = 0; i < 8; i++) begin
      cmd(1'b1, 4'h2, 8'h00);
      exp_head = (i < 6) ? 8'(8'h83 + i) : ((i == 6) ? 8'hEE : 8'h00);
      total++; if (head !== exp_head) begin bad++; $display("FAIL xch_pop%0d_head got=%h exp=%h", i, head, exp_head); end
    end
    total++; if (status !== 8'h40) begin bad++; $display("FAIL xch_drain_status got=%h exp=40", status); end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_head;
    for (int i = 0; i < 8; i++) cmd(1'b1, 4'h1, 8'(8'hA0 + i));
    total++; if (status !== 8'h88 || head !== 8'hA0) begin bad++; $display("FAIL wrap_fill got=%h/%h exp=88/A0", status, head); end
    for (int i = 0; i < 8; i++) begin
      cmd(1'b1, 4'h2, 8'h00);
      exp_head = (i < 7) ? 8'(8'hA1 + i) : 8'h00;
      total++; if (head !== exp_head) begin bad++; $display("FAIL wrap_pop%0d got=%h exp=%h", i, head, exp_head); end
    end
    for (int i = 0; i < 8; i++) cmd(1'b1, 4'h1, 8'(8'hC0 + i));
    total++; if (status !== 8'h88 || head !== 8'hC0) begin bad++; $display("FAIL wrap_refill got=%h/%h exp=88/C0", status, head); end
    cmd(1'b1, 4'h3, 8'h00);
  endtask

  task automatic test_reset_mid();
    cmd(1'b1, 4'h1, 8'h01);
    cmd(1'b1, 4'h1, 8'h02);
    reset = 1'b1;
    cmd(1'b1, 4'h1, 8'h03);
    total++; if (status !== 8'h00 || ready !== 1'b0) begin bad++; $display("FAIL mid_rst got=%h/%b exp=00/0", status, ready); end
    reset = 1'b0;
    cmd(1'b0, 4'h0, 8'h00);
    total++; if (status !== 8'h40 || head !== 8'h00) begin bad++; $display("FAIL mid_rst_exit got=%h/%h exp=40/00", status, head); end
  endtask

  task automatic test_error();
    cmd(1'b1, 4'h1, 8'h10);
    cmd(1'b1, 4'h9, 8'h00);
    total++; if ({error, ready} !== 2'b10) begin bad++; $display("FAIL err_flags got=%b exp=10", {error, ready}); end
    total++; if (head !== 8'h00 || status !== 8'h00) begin bad++; $display("FAIL err_outputs got=%h/%h exp=00/00", head, status); end
    cmd(1'b1, 4'h1, 8'h77);
    cmd(1'b1, 4'h3, 8'h00);
    total++; if (error !== 1'b1 || status !== 8'h00) begin bad++; $display("FAIL err_absorb got=%b/%h exp=1/00", error, status); end
    reset = 1'b1;
    cmd(1'b0, 4'h0, 8'h00);
    total++; if (error !== 1'b0) begin bad++; $display("FAIL err_reset got=%b exp=0", error); end
    reset = 1'b0;
    cmd(1'b0, 4'h0, 8'h00);
    total++; if (ready !== 1'b1 || status !== 8'h40 || head !== 8'h00) begin bad++; $display("FAIL err_recover got=%b/%h/%h exp=1/40/00", ready, status, head); end
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    reset    = 1'b1;
    inst_wen = 1'b0;
    inst     = 12'h000;
    test_reset();
    test_push_pop();
    test_hold_nop();
    test_overflow();
    test_underflow_xch();
    test_xch_full();
    test_wrap();
    test_reset_mid();
    test_error();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
